// File: rtl/pid_pkg.sv
// Shared widths and saturation helper for the PID controller (optional PID_ANTI_WINDUP_EN lives in the top).
// Pure declarations: no logic, no latency, no flow control.
package pid_pkg;

  localparam int P_INT_W  = 8;
  localparam int P_FRAC_W = 8;
  localparam int P_PV_W   = 8;
  localparam int P_CTL_W  = 18;

  // Working width for saturation; must cover the widest sum in the datapath.
  localparam int SAT_W = 64;

  function automatic int gain_w(input int int_w, input int frac_w);
    gain_w = int_w + frac_w;
  endfunction

  function automatic int integ_w(input int pv_w, input int int_w);
    integ_w = pv_w + int_w + 1;
  endfunction

  // Operand x zero-extended gain, plus two bits of headroom for the three-term sum.
  function automatic int sum_w(input int op_w, input int g_w);
    sum_w = op_w + g_w + 1 + 2;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] x,
                                                   input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo = -(SAT_W'(1) <<< (w - 1));
    if (x > hi)      sat_s = hi;
    else if (x < lo) sat_s = lo;
    else             sat_s = x;
  endfunction

endpackage

// File: rtl/pid_term_mult.sv
// Signed operand times unsigned gain, full precision, sign-extended to OUT_W.
// Combinational, zero latency, no flow control.
module pid_term_mult #(
  parameter int OP_W  = 9,
  parameter int G_W   = 16,
  parameter int OUT_W = 36
) (
  input  logic signed [OP_W-1:0]  op_i,
  input  logic        [G_W-1:0]   gain_i,
  output logic signed [OUT_W-1:0] prod_o
);

  logic signed [OUT_W-1:0] op_x;
  logic signed [OUT_W-1:0] gain_x;

  always_comb begin
    op_x   = OUT_W'(op_i);
    gain_x = $signed(OUT_W'({1'b0, gain_i}));
    prod_o = op_x * gain_x;
  end

endmodule

// File: rtl/pid_controller.sv
// Two-stage PID: error/integral/derivative registered, then saturated control word; optional PID_ANTI_WINDUP_EN.
// Error 1 and control_out 2 clk_en strobes after an input change; clk_en=0 holds all state.
module pid_controller
  import pid_pkg::*;
#(
  parameter int PID_INT_WIDTH  = P_INT_W,
  parameter int PID_FRAC_WIDTH = P_FRAC_W,
  parameter int PV_WIDTH       = P_PV_W,
  parameter int CONTROL_WIDTH  = P_CTL_W
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    clk_en,
  input  logic                                    en,
  input  logic [PID_INT_WIDTH+PID_FRAC_WIDTH-1:0] k_p,
  input  logic [PID_INT_WIDTH+PID_FRAC_WIDTH-1:0] k_i,
  input  logic [PID_INT_WIDTH+PID_FRAC_WIDTH-1:0] k_d,
  input  logic [PV_WIDTH-1:0]                     setpoint,
  input  logic [PV_WIDTH-1:0]                     feedback,
  output logic signed [PV_WIDTH:0]                error,
  output logic signed [CONTROL_WIDTH-1:0]         control_out
);

  localparam int GW = gain_w(PID_INT_WIDTH, PID_FRAC_WIDTH);
  localparam int EW = PV_WIDTH + 1;
  localparam int DW = PV_WIDTH + 2;
  localparam int IW = integ_w(PV_WIDTH, PID_INT_WIDTH);
  localparam int SW = sum_w(IW, GW);

  logic signed [EW-1:0]            err_q,   err_d;
  logic signed [DW-1:0]            deriv_q, deriv_d;
  logic signed [IW-1:0]            integ_q, integ_d;
  logic signed [CONTROL_WIDTH-1:0] ctl_q,   ctl_d;
  logic signed [SW-1:0]            p_term, i_term, d_term, sum, sum_sh;
  logic                            integ_hold;

  pid_term_mult #(.OP_W(EW), .G_W(GW), .OUT_W(SW)) u_p_mult (
    .op_i(err_q), .gain_i(k_p), .prod_o(p_term));
  pid_term_mult #(.OP_W(IW), .G_W(GW), .OUT_W(SW)) u_i_mult (
    .op_i(integ_q), .gain_i(k_i), .prod_o(i_term));
  pid_term_mult #(.OP_W(DW), .G_W(GW), .OUT_W(SW)) u_d_mult (
    .op_i(deriv_q), .gain_i(k_d), .prod_o(d_term));

`ifdef PID_ANTI_WINDUP_EN
  localparam logic signed [CONTROL_WIDTH-1:0] CTL_MAX = {1'b0, {(CONTROL_WIDTH-1){1'b1}}};
  localparam logic signed [CONTROL_WIDTH-1:0] CTL_MIN = {1'b1, {(CONTROL_WIDTH-1){1'b0}}};
`endif

  always_comb begin
    err_d   = $signed({1'b0, setpoint}) - $signed({1'b0, feedback});
    deriv_d = DW'(err_d) - DW'(err_q);
`ifdef PID_ANTI_WINDUP_EN
    // Stop integrating while the output is pinned and the error would push it further.
    integ_hold = ((ctl_q == CTL_MAX) || (ctl_q == CTL_MIN)) && (err_d != '0) &&
                 (err_d[EW-1] == ctl_q[CONTROL_WIDTH-1]);
`else
    integ_hold = 1'b0;
`endif
    integ_d = integ_hold ? integ_q
                         : IW'(sat_s(SAT_W'(integ_q) + SAT_W'(err_d), IW));
    sum     = p_term + i_term + d_term;
    sum_sh  = sum >>> PID_FRAC_WIDTH;
    ctl_d   = CONTROL_WIDTH'(sat_s(SAT_W'(sum_sh), CONTROL_WIDTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q   <= '0;
      deriv_q <= '0;
      integ_q <= '0;
      ctl_q   <= '0;
    end else if (clk_en) begin
      if (en) begin
        err_q   <= err_d;
        deriv_q <= deriv_d;
        integ_q <= integ_d;
        ctl_q   <= ctl_d;
      end else begin
        err_q   <= '0;
        deriv_q <= '0;
        integ_q <= '0;
        ctl_q   <= '0;
      end
    end
  end

  assign error       = err_q;
  assign control_out = ctl_q;

endmodule

// File: tb/tb_pid_controller.sv
// Directed bench for pid_controller: stimulus queues hand-computed results, a monitor checks them.
// Expected values are per clock edge; clk_en low cycles expect held outputs.
module tb_pid_controller;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_en;
  logic               en;
  logic [15:0]        k_p, k_i, k_d;
  logic [7:0]         setpoint, feedback;
  logic signed [8:0]  error;
  logic signed [17:0] control_out;

  typedef struct {
    bit    chk;
    int    err;
    int    ctl;
    string nm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  pid_controller dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .en(en),
    .k_p(k_p), .k_i(k_i), .k_d(k_d),
    .setpoint(setpoint), .feedback(feedback),
    .error(error), .control_out(control_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (x.chk) begin
        total++;
        if (error !== 9'(x.err)) begin
          bad++;
          $display("FAIL %s error: got %0d want %0d", x.nm, error, x.err);
        end
        total++;
        if (control_out !== 18'(x.ctl)) begin
          bad++;
          $display("FAIL %s control_out: got %0d want %0d", x.nm, control_out, x.ctl);
        end
      end
    end
  end

  task automatic cyc(input bit chk, input int e, input int c, input string nm);
    exp_t x;
    x.chk = chk;
    x.err = e;
    x.ctl = c;
    x.nm  = nm;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit chk, input int e, input int c, input string nm);
    for (int i = 0; i < n; i++) cyc(chk, e, c, nm);
  endtask

  task automatic clear_state();
    en = 1'b0;
    cyc(1, 0, 0, "en_clear");
    en = 1'b1;
  endtask

  initial begin
    reset = 1'b0; clk_en = 1'b1; en = 1'b1;
    k_p = 16'h0F00; k_i = 16'h0000; k_d = 16'h0000;
    setpoint = 8'd0; feedback = 8'd14;
    @(negedge clk);
    run(3, 1, 0, 0, "reset_hold");

    // Proportional only: 15.0 * (5-14)
    reset = 1'b1; setpoint = 8'd5;
    cyc(1, -9, 0, "p_first");
    run(3, 1, -9, -135, "p_steady");
    clear_state();

    // Integral only with mid-run clk_en stall
    k_p = 16'h0000; k_i = 16'h0100; setpoint = 8'd10; feedback = 8'd0;
    cyc(1, 10, 0, "i_ramp0");
    cyc(1, 10, 10, "i_ramp1");
    cyc(1, 10, 20, "i_ramp2");
    cyc(1, 10, 30, "i_ramp3");
    cyc(1, 10, 40, "i_ramp4");
    clk_en = 1'b0;
    run(5, 1, 10, 40, "clk_en_hold");
    clk_en = 1'b1;
    cyc(1, 10, 50, "i_resume0");
    cyc(1, 10, 60, "i_resume1");
    en = 1'b0;
    cyc(1, 0, 0, "en_drop");
    cyc(1, 0, 0, "en_low");
    en = 1'b1;

    // Derivative only: step 0 -> 20 gives a one-sample pulse
    k_i = 16'h0000; k_d = 16'h0100; setpoint = 8'd0;
    cyc(1, 0, 0, "d_idle");
    setpoint = 8'd20;
    cyc(1, 20, 0, "d_step");
    cyc(1, 20, 20, "d_pulse");
    cyc(1, 20, 0, "d_after0");
    cyc(1, 20, 0, "d_after1");
    clear_state();

    // Output saturation, both signs; checks floor rounding just below the limit
    k_d = 16'h0000; k_p = 16'hFFFF; k_i = 16'hFFFF; setpoint = 8'd255; feedback = 8'd0;
    cyc(1, 255, 0, "satp0");
    cyc(1, 255, 130558, "satp1");
    run(2, 1, 255, 131071, "satp_clamp");
    clear_state();
    setpoint = 8'd0; feedback = 8'd255;
    cyc(1, -255, 0, "satn0");
    cyc(1, -255, -130559, "satn1");
    run(2, 1, -255, -131072, "satn_clamp");
    clear_state();

    // Integrator saturation: tiny k_i exposes any wrap of the 17-bit integral
    k_p = 16'h0000; k_i = 16'h0001; setpoint = 8'd255; feedback = 8'd0;
    cyc(1, 255, 0, "isat_p0");
    cyc(1, 255, 0, "isat_p1");
    cyc(1, 255, 1, "isat_p2");
    run(300, 0, 0, 0, "");
    run(2, 1, 255, 255, "isat_pos");
    clear_state();
    setpoint = 8'd0; feedback = 8'd255;
    run(300, 0, 0, 0, "");
    run(2, 1, -255, -256, "isat_neg");
    en = 1'b0;
    cyc(1, 0, 0, "final_clear");

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pid_controller.md
Name: pid_controller

Overview:
- Discrete-time PID controller for closed-loop regulation of a process variable, for example motor tach count.
- Computes the error between setpoint and feedback and combines proportional, integral and derivative terms using unsigned fixed-point gains.
- Produces a saturated signed control word that drives the downstream PWM generator.
- Updates once per clk_en sample strobe.

Parameters:
- PID_INT_WIDTH, 8, integer bits of each gain.
- PID_FRAC_WIDTH, 8, fractional bits of each gain.
- PV_WIDTH, 8, width of setpoint and feedback.
- CONTROL_WIDTH, 18, width of the signed control_out.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clk_en  in  1  sample strobe; state advances only on clk edges where clk_en=1.
- en  in  1  controller enable.
- k_p  in  PID_INT_WIDTH+PID_FRAC_WIDTH  unsigned proportional gain.
- k_i  in  PID_INT_WIDTH+PID_FRAC_WIDTH  unsigned integral gain.
- k_d  in  PID_INT_WIDTH+PID_FRAC_WIDTH  unsigned derivative gain.
- setpoint  in  PV_WIDTH  unsigned target value.
- feedback  in  PV_WIDTH  unsigned measured value.
- error  out  PV_WIDTH+1  signed registered error, setpoint−feedback.
- control_out  out  CONTROL_WIDTH  signed saturated control word.

Behaviour:
- Gain format: Q(PID_INT_WIDTH).(PID_FRAC_WIDTH), unsigned; 16'h0F00 = 15.0, 16'h0080 = 0.5.
- Reset (reset=0, asynchronous): error, prev_error, integral, derivative and control_out all clear to 0.
- clk_en=0: all registers hold.
- Stage 1, on clk_en=1 and en=1:
  - error <= setpoint − feedback (zero-extended, exact, PV_WIDTH+1 bits).
  - derivative <= (setpoint−feedback) − error.
  - integral <= sat_I(integral + (setpoint−feedback)).
  - prev_error is held by the error register itself.
- Stage 2, on clk_en=1 and en=1:
  - sum = k_p·error + k_i·integral + k_d·derivative, with gains zero-extended and computed in full-precision signed arithmetic.
  - control_out <= sat_C(sum >>> PID_FRAC_WIDTH), an arithmetic shift, i.e. rounding toward −∞.
- Latency: a setpoint/feedback change appears in error 1 enabled edge later and in control_out 2 enabled edges later.
- Integrator: signed, width PV_WIDTH+PID_INT_WIDTH+1; saturates at its min/max and never wraps.
- sat_C clamps to the range −2^(CONTROL_WIDTH−1) .. 2^(CONTROL_WIDTH−1)−1.
- First sample after reset: the derivative equals the error, since prev_error=0.
- en=0 with clk_en=1: error, integral, derivative and control_out clear to 0 synchronously, so bumpless restart begins from zero state.
- Gains may change at any time; the new values are used at the next enabled stage-2 edge.

Optional Feature:
- Macro: PID_ANTI_WINDUP_EN.
- Defined: conditional integration. The integral is not updated on a sample where control_out is currently saturated and the new error has the same sign as control_out.
- Undefined: the integral always accumulates, bounded only by its own saturation.

Decomposition:
- Package pid_pkg holds:
  - Derived width localparams: gain width, integrator width, product/sum width.
  - A saturating signed-resize function shared by sat_I and sat_C.
- One sub-module, pid_term_mult: signed error × unsigned gain multiplier, instantiated three times for P, I and D.

Test Plan:
1. Reset held low with feedback=14, setpoint=0 → error=0, control_out=0; outputs stay 0 until reset releases.
2. k_p=16'h0F00, k_i=k_d=0, setpoint=5, feedback=14, clk_en=1 → error=−9 after 1 edge, control_out=−135 after 2 edges, stable thereafter.
3. k_i=16'h0100, k_p=k_d=0, setpoint=10, feedback=0 → integral 10, 20, 30…; control_out ramps by 10 per enabled edge.
4. k_d=16'h0100 only, setpoint stepped 0→20 with feedback=0 → control_out pulses 20 for one sample, then returns to 0.
5. k_p=16'hFFFF, setpoint=255, feedback=0 → control_out clamps at 131071. Reverse the inputs → clamps at −131072.
6. Toggle clk_en low for 5 cycles mid-run → all outputs hold. Drop en with clk_en high → outputs clear to 0 on the next edge.
